fp_add_sequencer: RTL

- Parametrised multi-cycle control sequencer for the fixed-point-mantissa floating-point adder datapath.
- Successor to the Go/Ready adder control FSM, generalised in the following ways:
  - any EXPBITS/MANTISSABITS, with all index constants derived from parameters;
  - valid/ready handshakes on input and output, with output backpressure;
  - special-operand bypass;
  - subnormal-aware left-shift clamping;
  - exponent-overflow-to-infinity;
  - a bounded re-round loop.
- Sits between the operand registers and the result register; drives alignment, normalisation and rounding mux/enable strobes.

---
 rtl/fp_add_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle control sequencer for the floating-point adder datapath.
// Clock/Reset; InValid/InReady operand handshake; classifier, alignment, FFO, rounding
// and overflow status in; alignment/normalise/round strobes, ForceSpecial/ForceInf and
// OutValid/OutReady result handshake out. Every strobe is registered from next state.
module fp_add_sequencer #(
  parameter int EXPBITS = 8,
  parameter int MANTISSABITS = 23,
  parameter int MAXROUND = 2,
  localparam int SAW = $clog2(MANTISSABITS + 2),
  localparam int RAW = $clog2(MANTISSABITS + 3)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic               SpecialIn,
  input  logic               EffSubIn,
  input  logic               ExpSet,
  input  logic [EXPBITS-1:0] ExpDiff,
  input  logic               FFOValid,
  input  logic [SAW-1:0]     FFOIndex,
  input  logic [SAW-1:0]     MaxLeftShift,
  input  logic               RoundCarry,
  input  logic               ExpOverflow,
  output logic               EffSub,
  output logic               SelExpMux,
  output logic               SelSRMuxL,
  output logic               SelSRMuxG,
  output logic               ShiftRightEnable,
  output logic [RAW-1:0]     ShiftRightAmount,
  output logic               SREn,
  output logic               SLEn,
  output logic               NoShift,
  output logic [SAW-1:0]     ShiftAmount,
  output logic               SelMuxR,
  output logic               ForceSpecial,
  output logic               ForceInf,
  output logic               OutValid,
  input  logic               OutReady
);

  localparam int CW = $clog2(MAXROUND + 2);
  localparam logic [31:0] SRLIM = 32'(MANTISSABITS + 2);
  localparam logic [SAW-1:0] IDXONE = SAW'(MANTISSABITS);
  localparam logic [SAW-1:0] IDXCARRY = SAW'(MANTISSABITS + 1);

  typedef enum logic [3:0] {
    IDLE, SPECIAL, ALIGNEQ, ALIGNGT, ALIGNLT,
    SR, SL, NOSHIFT, ROUND, RESULT
  } state_t;

  state_t state, nxt;
  logic [CW-1:0] rcnt, cnt_n;
  logic ovf, ovf_n;
  logic [RAW-1:0] sr_amt;
  logic [SAW-1:0] sl_dist, sl_amt;
  logic ffo_sr, ffo_ns;

  assign InReady = (state == IDLE);

  // Distances are clamped: right shifts beyond the guard
  // bits are all-sticky; left shifts stop at the subnormal floor.
  always_comb begin
    sr_amt = (32'(ExpDiff) > SRLIM) ? RAW'(SRLIM) : RAW'(ExpDiff);
    sl_dist = IDXONE - FFOIndex;
    sl_amt = (sl_dist > MaxLeftShift) ? MaxLeftShift : sl_dist;
    ffo_sr = FFOValid && (FFOIndex >= IDXCARRY);
    ffo_ns = !FFOValid || (FFOIndex == IDXONE);
  end

  always_comb begin
    nxt = state;
    cnt_n = rcnt;
    ovf_n = ovf;
    unique case (state)
      IDLE: begin
        if (InValid) begin
          if (SpecialIn) nxt = SPECIAL;
          else if (ExpDiff == '0) nxt = ALIGNEQ;
          else if (ExpSet) nxt = ALIGNGT;
          else nxt = ALIGNLT;
        end
      end
      SPECIAL: nxt = RESULT;
      ALIGNEQ, ALIGNGT, ALIGNLT: begin
        if (ffo_sr) nxt = SR;
        else if (ffo_ns) nxt = NOSHIFT;
        else nxt = SL;
      end
      SR, SL, NOSHIFT: begin
        if (ExpOverflow) begin
          ovf_n = 1'b1;
          nxt = RESULT;
        end else if (RoundCarry) begin
          nxt = ROUND;
          cnt_n = CW'(1);
        end else begin
          nxt = RESULT;
        end
      end
      ROUND: begin
        if (ExpOverflow) begin
          ovf_n = 1'b1;
          nxt = RESULT;
        end else if (!RoundCarry) begin
          nxt = RESULT;
        end else if (rcnt < CW'(MAXROUND)) begin
          cnt_n = rcnt + CW'(1);
        end else begin
          nxt = RESULT;
        end
      end
      RESULT: begin
        if (OutReady) begin
          nxt = IDLE;
          cnt_n = '0;
          ovf_n = 1'b0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      rcnt <= '0;
      ovf <= 1'b0;
      EffSub <= 1'b0;
      SelExpMux <= 1'b0;
      SelSRMuxL <= 1'b0;
      SelSRMuxG <= 1'b0;
      ShiftRightEnable <= 1'b0;
      ShiftRightAmount <= '0;
      SREn <= 1'b0;
      SLEn <= 1'b0;
      NoShift <= 1'b0;
      ShiftAmount <= '0;
      SelMuxR <= 1'b0;
      ForceSpecial <= 1'b0;
      ForceInf <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      state <= nxt;
      rcnt <= cnt_n;
      ovf <= ovf_n;
      if (state == IDLE && InValid) EffSub <= EffSubIn;
      SelExpMux <= (nxt == ALIGNEQ) || (nxt == ALIGNGT);
      SelSRMuxG <= (nxt == ALIGNEQ) || (nxt == ALIGNGT);
      SelSRMuxL <= (nxt == ALIGNLT);
      ShiftRightEnable <= (nxt == ALIGNGT) || (nxt == ALIGNLT);
      ShiftRightAmount <= ((nxt == ALIGNGT) || (nxt == ALIGNLT)) ? sr_amt : '0;
      SREn <= (nxt == SR) || (nxt == ROUND);
      SLEn <= (nxt == SL);
      NoShift <= (nxt == NOSHIFT);
      // SL is only entered from alignment, where FFO is valid.
      ShiftAmount <= (nxt == SL) ? sl_amt : '0;
      SelMuxR <= (nxt == ROUND);
      ForceSpecial <= (nxt == SPECIAL);
      ForceInf <= (nxt == RESULT) && ovf_n;
      OutValid <= (nxt == RESULT);
    end
  end

endmodule
